// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU, HI/LO register pair, 32x32 multiplier and an
// iterative restoring divider that stalls the pipeline while it runs.
//
// state     | meaning
// ----------+----------------------------------------------------------------
// ST_IDLE   | accepting instructions; a DIV latches its operands here
// ST_BUSY   | one restoring quotient bit per cycle, 32 cycles
// ST_DONE   | stall released, quotient/remainder written to LO/HI
module exe_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [2:0]  id_alu_sel_i,
    input  logic [7:0]  id_alu_op_i,
    input  logic [31:0] id_reg1_i,
    input  logic [31:0] id_reg2_i,
    input  logic        id_wreg_i,
    input  logic [4:0]  id_wd_i,
    input  logic        id_mt_hi_i,
    input  logic        id_mt_lo_i,
    input  logic        id_mf_hi_i,
    input  logic        id_mf_lo_i,
    input  logic        id_rmem_i,
    input  logic        id_wmem_i,
    input  logic [31:0] id_mem_io_addr_i,
    output logic        exe_wreg_o,
    output logic [4:0]  exe_wd_o,
    output logic [31:0] exe_wdata_o,
    output logic        exe_rmem_o,
    output logic        exe_wmem_o,
    output logic [31:0] exe_mem_io_addr_o,
    output logic [31:0] exe_mem_wdata_o,
    output logic        stall_req_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [2:0] SEL_LOGIC = 3'd1;
    localparam logic [2:0] SEL_SHIFT = 3'd2;
    localparam logic [2:0] SEL_ARITH = 3'd3;
    localparam logic [2:0] SEL_MOVE  = 3'd4;
    localparam logic [2:0] SEL_MUL   = 3'd5;
    localparam logic [2:0] SEL_DIV   = 3'd6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] dsr_q, dsr_d;
    logic [31:0] rem_q, rem_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        dz_q, dz_d;

    logic [31:0] alu_res;
    logic [4:0]  shamt;
    logic [63:0] mul_a, mul_b, mul_p;
    logic        mul_valid;
    logic        is_div, div_signed;
    logic [31:0] abs1, abs2;
    logic [32:0] shifted, diff;
    logic        q_bit;
    logic [31:0] quot_fix, rem_fix;

    assign shamt = id_reg1_i[4:0];

    always_comb begin
        alu_res = '0;
        case (id_alu_sel_i)
            SEL_LOGIC: begin
                case (id_alu_op_i)
                    8'd0:    alu_res = id_reg1_i & id_reg2_i;
                    8'd1:    alu_res = id_reg1_i | id_reg2_i;
                    8'd2:    alu_res = id_reg1_i ^ id_reg2_i;
                    8'd3:    alu_res = ~(id_reg1_i | id_reg2_i);
                    default: alu_res = '0;
                endcase
            end
            SEL_SHIFT: begin
                case (id_alu_op_i)
                    8'd0:    alu_res = id_reg2_i << shamt;
                    8'd1:    alu_res = id_reg2_i >> shamt;
                    8'd2:    alu_res = $signed(id_reg2_i) >>> shamt;
                    default: alu_res = '0;
                endcase
            end
            SEL_ARITH: begin
                case (id_alu_op_i)
                    8'd0:    alu_res = id_reg1_i + id_reg2_i;
                    8'd1:    alu_res = id_reg1_i - id_reg2_i;
                    8'd2:    alu_res = {31'b0, ($signed(id_reg1_i) < $signed(id_reg2_i))};
                    8'd3:    alu_res = {31'b0, (id_reg1_i < id_reg2_i)};
                    default: alu_res = '0;
                endcase
            end
            SEL_MOVE: begin
                if (id_mf_hi_i)
                    alu_res = hi_q;
                else if (id_mf_lo_i)
                    alu_res = lo_q;
            end
            default: alu_res = '0;
        endcase
    end

    // Sign- or zero-extend to 64 bits so one unsigned multiply covers both ops.
    assign mul_valid = (id_alu_sel_i == SEL_MUL) && ((id_alu_op_i == 8'd0) || (id_alu_op_i == 8'd1));
    assign mul_a     = (id_alu_op_i == 8'd0) ? {{32{id_reg1_i[31]}}, id_reg1_i} : {32'b0, id_reg1_i};
    assign mul_b     = (id_alu_op_i == 8'd0) ? {{32{id_reg2_i[31]}}, id_reg2_i} : {32'b0, id_reg2_i};
    assign mul_p     = mul_a * mul_b;

    assign is_div     = (id_alu_sel_i == SEL_DIV);
    assign div_signed = (id_alu_op_i == 8'd0);
    assign abs1       = (div_signed && id_reg1_i[31]) ? (32'd0 - id_reg1_i) : id_reg1_i;
    assign abs2       = (div_signed && id_reg2_i[31]) ? (32'd0 - id_reg2_i) : id_reg2_i;

    // Quotient bits shift into dvd_q as dividend bits shift out.
    assign shifted  = {rem_q, dvd_q[31]};
    assign diff     = shifted - {1'b0, dsr_q};
    assign q_bit    = ~diff[32];
    assign quot_fix = q_neg_q ? (32'd0 - dvd_q) : dvd_q;
    assign rem_fix  = r_neg_q ? (32'd0 - rem_q) : rem_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;
        if (flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_div) begin
                        cnt_d   = '0;
                        rem_d   = '0;
                        q_neg_d = div_signed & (id_reg1_i[31] ^ id_reg2_i[31]);
                        r_neg_d = div_signed & id_reg1_i[31];
                        if (id_reg2_i == 32'd0) begin
                            dz_d    = 1'b1;
                            dvd_d   = id_reg1_i;
                            dsr_d   = '0;
                            state_d = ST_DONE;
                        end else begin
                            dz_d    = 1'b0;
                            dvd_d   = abs1;
                            dsr_d   = abs2;
                            state_d = ST_BUSY;
                        end
                    end else if (mul_valid) begin
                        hi_d = mul_p[63:32];
                        lo_d = mul_p[31:0];
                    end else if (id_alu_sel_i == SEL_MOVE) begin
                        if (id_mt_hi_i)
                            hi_d = id_reg1_i;
                        if (id_mt_lo_i)
                            lo_d = id_reg1_i;
                    end
                end
                ST_BUSY: begin
                    dvd_d = {dvd_q[30:0], q_bit};
                    rem_d = q_bit ? diff[31:0] : shifted[31:0];
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31)
                        state_d = ST_DONE;
                end
                ST_DONE: begin
                    hi_d    = dz_q ? dvd_q : rem_fix;
                    lo_d    = dz_q ? 32'hFFFF_FFFF : quot_fix;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
        end
    end

    // Pass-throughs are gated so every output reads zero while reset is held.
    assign stall_req_o       = rst & ~flush_i & (((state_q == ST_IDLE) & is_div) | (state_q == ST_BUSY));
    assign exe_wdata_o       = rst ? alu_res : 32'd0;
    assign exe_wreg_o        = rst & id_wreg_i;
    assign exe_wd_o          = rst ? id_wd_i : 5'd0;
    assign exe_rmem_o        = rst & id_rmem_i;
    assign exe_wmem_o        = rst & id_wmem_i;
    assign exe_mem_io_addr_o = rst ? id_mem_io_addr_i : 32'd0;
    assign exe_mem_wdata_o   = rst ? id_reg2_i : 32'd0;
    assign hi_o              = hi_q;
    assign lo_o              = lo_q;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: a per-cycle compare against a behavioural model
// of the execute rules, plus hand-computed literal checks.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_i = 1'b0;
    logic [2:0]  id_alu_sel_i = '0;
    logic [7:0]  id_alu_op_i = '0;
    logic [31:0] id_reg1_i = '0;
    logic [31:0] id_reg2_i = '0;
    logic        id_wreg_i = 1'b0;
    logic [4:0]  id_wd_i = '0;
    logic        id_mt_hi_i = 1'b0;
    logic        id_mt_lo_i = 1'b0;
    logic        id_mf_hi_i = 1'b0;
    logic        id_mf_lo_i = 1'b0;
    logic        id_rmem_i = 1'b0;
    logic        id_wmem_i = 1'b0;
    logic [31:0] id_mem_io_addr_i = '0;
    logic        exe_wreg_o;
    logic [4:0]  exe_wd_o;
    logic [31:0] exe_wdata_o;
    logic        exe_rmem_o;
    logic        exe_wmem_o;
    logic [31:0] exe_mem_io_addr_o;
    logic [31:0] exe_mem_wdata_o;
    logic        stall_req_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    exe_stage dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .id_alu_sel_i(id_alu_sel_i), .id_alu_op_i(id_alu_op_i),
        .id_reg1_i(id_reg1_i), .id_reg2_i(id_reg2_i),
        .id_wreg_i(id_wreg_i), .id_wd_i(id_wd_i),
        .id_mt_hi_i(id_mt_hi_i), .id_mt_lo_i(id_mt_lo_i),
        .id_mf_hi_i(id_mf_hi_i), .id_mf_lo_i(id_mf_lo_i),
        .id_rmem_i(id_rmem_i), .id_wmem_i(id_wmem_i),
        .id_mem_io_addr_i(id_mem_io_addr_i),
        .exe_wreg_o(exe_wreg_o), .exe_wd_o(exe_wd_o), .exe_wdata_o(exe_wdata_o),
        .exe_rmem_o(exe_rmem_o), .exe_wmem_o(exe_wmem_o),
        .exe_mem_io_addr_o(exe_mem_io_addr_o), .exe_mem_wdata_o(exe_mem_wdata_o),
        .stall_req_o(stall_req_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          vec_id  = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;
    logic        exp_stall = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_wdata(input logic [2:0] sel, input logic [7:0] op,
                                                input logic [31:0] a, input logic [31:0] b,
                                                input logic mfh, input logic mfl,
                                                input logic [31:0] h, input logic [31:0] l);
        logic [4:0] sh;
        sh = a[4:0];
        case (sel)
            3'd1: case (op)
                8'd0: return a & b;
                8'd1: return a | b;
                8'd2: return a ^ b;
                8'd3: return ~(a | b);
                default: return 32'd0;
            endcase
            3'd2: case (op)
                8'd0: return b << sh;
                8'd1: return b >> sh;
                8'd2: return $signed(b) >>> sh;
                default: return 32'd0;
            endcase
            3'd3: case (op)
                8'd0: return a + b;
                8'd1: return a - b;
                8'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                8'd3: return (a < b) ? 32'd1 : 32'd0;
                default: return 32'd0;
            endcase
            3'd4: return mfh ? h : (mfl ? l : 32'd0);
            default: return 32'd0;
        endcase
    endfunction

    always @(negedge clk) begin
        chk("wdata", exe_wdata_o, rst ? model_wdata(id_alu_sel_i, id_alu_op_i, id_reg1_i, id_reg2_i,
                                                    id_mf_hi_i, id_mf_lo_i, exp_hi, exp_lo) : 32'd0);
        chk("ctl", {24'b0, exe_wd_o, exe_wreg_o, exe_rmem_o, exe_wmem_o},
            rst ? {24'b0, id_wd_i, id_wreg_i, id_rmem_i, id_wmem_i} : 32'd0);
        chk("addr", exe_mem_io_addr_o, rst ? id_mem_io_addr_i : 32'd0);
        chk("mem_wdata", exe_mem_wdata_o, rst ? id_reg2_i : 32'd0);
        chk("stall", {31'b0, stall_req_o}, {31'b0, rst & exp_stall});
        chk("hi", hi_o, exp_hi);
        chk("lo", lo_o, exp_lo);
    end

    task automatic set_op(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        vec_id++;
        id_alu_sel_i     = sel;
        id_alu_op_i      = op;
        id_reg1_i        = a;
        id_reg2_i        = b;
        id_wreg_i        = 1'b1;
        id_wd_i          = 5'(vec_id);
        id_rmem_i        = vec_id[0];
        id_wmem_i        = vec_id[1];
        id_mem_io_addr_i = a ^ b ^ 32'(vec_id);
        id_mt_hi_i       = 1'b0;
        id_mt_lo_i       = 1'b0;
        id_mf_hi_i       = 1'b0;
        id_mf_lo_i       = 1'b0;
    endtask

    // One non-divide instruction: HI/LO model advances at the edge that ends it.
    task automatic run1();
        logic [31:0] nh, nl;
        logic [63:0] p;
        nh = exp_hi;
        nl = exp_lo;
        if (id_alu_sel_i == 3'd5 && id_alu_op_i == 8'd0) begin
            p  = 64'(longint'($signed(id_reg1_i)) * longint'($signed(id_reg2_i)));
            nh = p[63:32];
            nl = p[31:0];
        end else if (id_alu_sel_i == 3'd5 && id_alu_op_i == 8'd1) begin
            p  = {32'b0, id_reg1_i} * {32'b0, id_reg2_i};
            nh = p[63:32];
            nl = p[31:0];
        end else if (id_alu_sel_i == 3'd4) begin
            if (id_mt_hi_i) nh = id_reg1_i;
            if (id_mt_lo_i) nl = id_reg1_i;
        end
        @(posedge clk); #1;
        exp_hi = nh;
        exp_lo = nl;
    endtask

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input int flush_at, input int rst_at);
        int          ncyc, nst, sa, sb;
        logic [31:0] eh, el;
        logic        aborted;
        aborted = 1'b0;
        nst     = 0;
        ncyc    = (b == 32'd0) ? 2 : 34;
        if (b == 32'd0) begin
            eh = a; el = 32'hFFFF_FFFF;
        end else if (sgn) begin
            sa = $signed(a); sb = $signed(b);
            el = 32'(sa / sb); eh = 32'(sa % sb);
        end else begin
            el = a / b; eh = a % b;
        end
        set_op(3'd6, sgn ? 8'd0 : 8'd1, a, b);
        for (int n = 0; n < ncyc; n++) begin
            if (n == flush_at) begin
                flush_i   = 1'b1;
                exp_stall = 1'b0;
                @(negedge clk);
                chk("flush stall low", {31'b0, stall_req_o}, 32'd0);
                @(posedge clk); #1;
                flush_i = 1'b0;
                set_op(3'd0, 8'd0, 32'd0, 32'd0);
                aborted = 1'b1;
                break;
            end
            if (n == rst_at) begin
                #2;
                rst       = 1'b0;
                exp_hi    = '0;
                exp_lo    = '0;
                exp_stall = 1'b0;
                #1;
                chk("rst imm stall", {31'b0, stall_req_o}, 32'd0);
                chk("rst imm hi", hi_o, 32'd0);
                chk("rst imm lo", lo_o, 32'd0);
                chk("rst imm ctl", {24'b0, exe_wd_o, exe_wreg_o, exe_rmem_o, exe_wmem_o}, 32'd0);
                chk("rst imm wdata", exe_wdata_o | exe_mem_wdata_o | exe_mem_io_addr_o, 32'd0);
                set_op(3'd0, 8'd0, 32'd0, 32'd0);
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b1;
                aborted = 1'b1;
                break;
            end
            exp_stall = (n < ncyc - 1);
            @(negedge clk);
            if (stall_req_o) nst++;
            @(posedge clk); #1;
        end
        if (!aborted) begin
            chk("div stall cycles", 32'(nst), (b == 32'd0) ? 32'd1 : 32'd33);
            exp_stall = 1'b0;
            exp_hi    = eh;
            exp_lo    = el;
            set_op(3'd0, 8'd0, 32'd0, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        logic [31:0] hold_hi, hold_lo;
        set_op(3'd3, 8'd0, 32'h5, 32'h7);
        repeat (2) @(posedge clk);
        #1;
        chk("reset stall", {31'b0, stall_req_o}, 32'd0);
        chk("reset hi", hi_o, 32'd0);
        chk("reset lo", lo_o, 32'd0);
        chk("reset wdata", exe_wdata_o, 32'd0);
        rst = 1'b1;

        for (int op = 0; op < 5; op++) begin
            set_op(3'd1, 8'(op), 32'hF0F0_1234, 32'h0FF0_5678);
            if (op == 0) begin
                @(negedge clk);
                chk("and lit", exe_wdata_o, 32'h00F0_1230);
            end
            run1();
        end
        for (int op = 0; op < 4; op++) begin
            set_op(3'd2, 8'(op), 32'd4, 32'h8000_00F0);
            if (op == 2) begin
                @(negedge clk);
                chk("sra lit", exe_wdata_o, 32'hF800_000F);
            end
            run1();
        end
        set_op(3'd3, 8'd1, 32'd5, 32'd7); @(negedge clk); chk("sub lit", exe_wdata_o, 32'hFFFF_FFFE); run1();
        set_op(3'd3, 8'd2, 32'd5, 32'd7); @(negedge clk); chk("slt lit", exe_wdata_o, 32'd1); run1();
        set_op(3'd3, 8'd3, 32'd5, 32'd7); @(negedge clk); chk("sltu lit", exe_wdata_o, 32'd1); run1();
        set_op(3'd3, 8'd0, 32'hFFFF_FFFF, 32'd2); run1();
        set_op(3'd3, 8'd2, 32'hFFFF_FFFF, 32'd1); run1();
        set_op(3'd3, 8'd3, 32'hFFFF_FFFF, 32'd1); run1();
        set_op(3'd3, 8'd4, 32'd1, 32'd1); run1();
        set_op(3'd7, 8'd0, 32'd3, 32'd4); run1();
        set_op(3'd0, 8'd0, 32'd3, 32'd4); run1();

        set_op(3'd4, 8'd0, 32'h1111, 32'd0); id_mt_hi_i = 1'b1; run1();
        set_op(3'd4, 8'd0, 32'h2222, 32'd0); id_mt_lo_i = 1'b1; run1();
        set_op(3'd4, 8'd0, 32'd0, 32'd0); id_mf_hi_i = 1'b1;
        @(negedge clk); chk("mfhi lit", exe_wdata_o, 32'h1111); run1();
        set_op(3'd4, 8'd0, 32'd0, 32'd0); id_mf_lo_i = 1'b1; run1();

        set_op(3'd5, 8'd0, 32'hFFFF_FFFF, 32'd2); run1();
        chk("muls hi lit", hi_o, 32'hFFFF_FFFF);
        chk("muls lo lit", lo_o, 32'hFFFF_FFFE);
        set_op(3'd5, 8'd1, 32'hFFFF_FFFF, 32'd2); run1();
        chk("mulu hi lit", hi_o, 32'd1);
        chk("mulu lo lit", lo_o, 32'hFFFF_FFFE);
        set_op(3'd4, 8'd0, 32'd0, 32'd0); id_mf_hi_i = 1'b1; run1();

        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, -1, -1);
        chk("div lo lit", lo_o, 32'hFFFF_FFFD);
        chk("div hi lit", hi_o, 32'hFFFF_FFFF);
        run1();
        do_div(32'd100, 32'd7, 1'b0, -1, -1);
        chk("divu lo lit", lo_o, 32'd14);
        chk("divu hi lit", hi_o, 32'd2);
        run1();
        do_div(32'd9, 32'd0, 1'b1, -1, -1);
        chk("div0 hi lit", hi_o, 32'd9);
        chk("div0 lo lit", lo_o, 32'hFFFF_FFFF);
        run1();
        do_div(32'd7, 32'hFFFF_FFFE, 1'b1, -1, -1); run1();
        do_div(32'hFFFF_FFFF, 32'd3, 1'b0, -1, -1); run1();

        hold_hi = exp_hi;
        hold_lo = exp_lo;
        do_div(32'd100, 32'd7, 1'b0, 11, -1);
        run1(); run1();
        chk("flush hi kept", hi_o, hold_hi);
        chk("flush lo kept", lo_o, hold_lo);

        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, -1, 21);
        run1();
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, -1, -1);
        chk("post-rst div lo", lo_o, 32'hFFFF_FFFD);
        chk("post-rst div hi", hi_o, 32'hFFFF_FFFF);
        run1(); run1();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
